// File: rtl/vpu_fb_pkg.sv
// Shared types and defaults for the VPU framebuffer pixel writer.
package vpu_fb_pkg;

  localparam int FB_H_RES      = 640;
  localparam int FB_V_RES      = 480;
  localparam int FB_COLOR_W    = 12;
  localparam int FB_ADDR_W     = 19;
  localparam int FB_FIFO_DEPTH = 8;
  localparam int FB_PIXELS     = FB_H_RES * FB_V_RES;

  // Writer control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } fbw_state_t;

  // One queued framebuffer write: linear address plus colour
  typedef struct packed {
    logic [FB_ADDR_W-1:0]  addr;
    logic [FB_COLOR_W-1:0] color;
  } pix_entry_t;

  // Linear framebuffer address of pixel (x, y) for a row pitch of h_res
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [9:0] x,
                                                    input logic [8:0] y,
                                                    input int         h_res);
    int lin;
    lin = int'(y) * h_res + int'(x);
    return FB_ADDR_W'(lin);
  endfunction

endpackage

// File: rtl/fb_pix_fifo.sv
// Small synchronous FIFO for queued pixel writes. Push and pop may occur in
// the same cycle; a push while full is discarded, a pop while empty is ignored.
module fb_pix_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 31
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; depth is a power of two so pointers wrap freely
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers: pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Framebuffer pixel writer: queues clipped pixels from the line generator,
// converts them to linear addresses and writes them through an arbitrated
// write port; also sweeps the whole screen with CLEAR_COLOR on request.
// Optional drop statistics: define FB_WRITER_STATS_EN to enable drop_cnt.
module fb_pixel_writer
  import vpu_fb_pkg::*;
#(
  parameter int                 H_RES       = FB_H_RES,
  parameter int                 V_RES       = FB_V_RES,
  parameter int                 COLOR_W     = FB_COLOR_W,
  parameter int                 ADDR_W      = FB_ADDR_W,
  parameter int                 FIFO_DEPTH  = FB_FIFO_DEPTH,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [9:0]         pix_x,
  input  logic [8:0]         pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  input  logic               clear_req,
  output logic               clear_done,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  input  logic               fb_gnt,
  output logic               busy,
  output logic [15:0]        drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  // The queued entry layout comes from the package, so widths must agree
  if (ADDR_W != FB_ADDR_W || COLOR_W != FB_COLOR_W) begin : g_bad_width
    $error("fb_pixel_writer: ADDR_W/COLOR_W must match vpu_fb_pkg");
  end
  if ((64'd1 << ADDR_W) < 64'(H_RES * V_RES)) begin : g_bad_addr
    $error("fb_pixel_writer: ADDR_W too small for H_RES*V_RES");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fb_pixel_writer: FIFO_DEPTH must be a power of two >= 2");
  end

  fbw_state_t        state_q, state_d;
  logic              clr_pend_q, clr_pend_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              out_vld_q, out_vld_d;
  pix_entry_t        out_q, out_d;

  pix_entry_t        fifo_din, fifo_dout;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              accept, in_range;

  // Ready depends only on registered state so it never combinationally follows a pop
  assign pix_ready = rst_n && !fifo_full && (state_q == IDLE) && !clr_pend_q;
  assign accept    = pix_valid && pix_ready;
  assign in_range  = (int'(pix_x) < H_RES) && (int'(pix_y) < V_RES);
  assign fifo_push = accept && in_range;

  assign fifo_din.addr  = pix_addr(pix_x, pix_y, H_RES);
  assign fifo_din.color = pix_color;

  // Refill the output stage whenever it is empty or its write completes now
  assign fifo_pop = !fifo_empty && (!out_vld_q || fb_gnt);

  fb_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(pix_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output stage next-state: load from FIFO head, or retire on grant
  always_comb begin
    out_vld_d = out_vld_q;
    out_d     = out_q;
    if (fifo_pop) begin
      out_vld_d = 1'b1;
      out_d     = fifo_dout;
    end else if (out_vld_q && fb_gnt) begin
      out_vld_d = 1'b0;
    end
  end

  // Clear sequencing: queue drains before the sweep, sweep advances only on grant
  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      IDLE: begin
        if (clear_req && !clr_pend_q) clr_pend_d = 1'b1;
        if (clr_pend_q && fifo_empty && !out_vld_q) begin
          state_d    = CLEAR;
          clr_pend_d = 1'b0;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        if (fb_gnt) begin
          if (clr_addr_q == LAST_ADDR) state_d = DONE;
          else                         clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (clear_req) clr_pend_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      clr_pend_q <= 1'b0;
      clr_addr_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      clr_addr_q <= clr_addr_d;
      out_vld_q  <= out_vld_d;
    end
  end

  // Output stage payload; qualified by out_vld_q so it carries no reset
  always_ff @(posedge clk) begin
    out_q <= out_d;
  end

  // Write port mux; everything is forced quiet while reset is asserted
  always_comb begin
    fb_we    = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    if (rst_n) begin
      if (state_q == CLEAR) begin
        fb_we    = 1'b1;
        fb_addr  = clr_addr_q;
        fb_wdata = CLEAR_COLOR;
      end else if (out_vld_q) begin
        fb_we    = 1'b1;
        fb_addr  = out_q.addr;
        fb_wdata = out_q.color;
      end
    end
  end

  assign clear_done = rst_n && (state_q == DONE);
  assign busy       = (state_q != IDLE) || !fifo_empty || out_vld_q || clr_pend_q;

`ifdef FB_WRITER_STATS_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of accepted-but-out-of-range pixels
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else if (accept && !in_range && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = rst_n ? drop_cnt_q : 16'd0;
`else
  assign drop_cnt = 16'd0;
`endif

endmodule
